instr_fetch_mem: RTL and testbench
==================================

Name: instr_fetch_mem

Overview:
- Parametrised, writable instruction memory with a registered read path and a valid/ready fetch handshake.
- Sits between the PC/fetch stage and decode of the 64-bit RISC-V-encoded datapath.
- Returns each 32-bit instruction together with pre-split decode fields.
- Adds range/alignment fault detection and a program-load port, so test programs are loaded at run time rather than hard-coded.

Parameters:
- ADDR_W, 64, width of the byte address from the PC.
- DEPTH, 256, number of 32-bit instruction words stored (power of 2, at least 2).
- BASE_ADDR, 40, byte address of word 0.
- NOP_INSTR, 32'h0000_0013, instruction returned on a fault (addi x0,x0,0).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  fetch request present
- req_ready  out  1  block can accept a request this cycle
- req_addr  in  ADDR_W  byte address of the requested instruction
- resp_valid  out  1  response registers hold a valid instruction
- resp_ready  in  1  consumer accepts the response
- instruction  out  32  fetched word
- opcode  out  7  instruction[6:0]
- rd  out  5  instruction[11:7]
- funct3  out  3  instruction[14:12]
- rs1  out  5  instruction[19:15]
- rs2  out  5  instruction[24:20]
- funct7_b5  out  1  instruction[30]
- fault  out  1  response came from a misaligned or out-of-range address
- load_en  in  1  program-load write strobe
- load_idx  in  $clog2(DEPTH)  word index to write
- load_data  in  32  word to write

Behaviour:
- Clock/reset: one clock domain; reset is synchronous, active-high. The clock port is clk and the reset port is reset.
- Reset values:
  - resp_valid=0, instruction=0, all field outputs 0, fault=0.
  - req_ready=1 from the first cycle after reset.
  - Memory contents are not cleared by reset.
- Handshake:
  - req_ready = !resp_valid | resp_ready (combinational).
  - A request is accepted when req_valid & req_ready at a rising edge.
  - Latency is exactly 1 cycle: response registers load on the accepting edge, and resp_valid=1 in the following cycle.
  - A response is consumed when resp_valid & resp_ready.
  - Same-edge consume and accept is a back-to-back transfer: resp_valid stays 1 and the registers hold the new data.
  - Sustained throughput is one instruction per cycle.
- Backpressure: while resp_valid & !resp_ready, every response output is held stable and req_ready=0. Requests presented in that window are not accepted, and the requester holds them.
- Idle: a consume with no new accept clears resp_valid to 0. The data outputs keep their last values and are don't-care while resp_valid=0.
- Address mapping: offset = req_addr - BASE_ADDR (ADDR_W-bit unsigned arithmetic); word index = offset[..:2].
- Faults: fault=1 when req_addr[1:0]!=0, or req_addr < BASE_ADDR, or req_addr >= BASE_ADDR + 4*DEPTH.
  - The out-of-range test uses an ADDR_W+1-bit compare so no wrap-around aliasing occurs.
  - On a fault, instruction=NOP_INSTR and the fields are decoded from NOP_INSTR. The memory is not read.
- Decode fields: registered together with the instruction word, always consistent with the instruction output.
- Program load: load_en writes load_data to mem[load_idx] at the rising edge. It is independent of the handshake and is permitted during reset.
- Load/fetch collision: a load and an accepted fetch to the same index on the same edge return the OLD word (read-before-write). The new word is visible from the next accepted fetch.
- Reset mid-operation: reset drops any pending response (resp_valid→0). A request presented in a reset cycle is not accepted.
- No X on outputs after reset. Unloaded words read whatever the array holds; the bench loads before fetching.

Decomposition:
- Shared package imem_pkg holds:
  - INSTR_W=32 and NOP_INSTR.
  - Field bit-position constants for OPCODE, RD, FUNCT3, RS1, RS2 and FUNCT7_B5.
  - A struct typedef decoded_instr_t grouping the field outputs.
- One natural sub-module, imem_array: a synchronous read-before-write 1R1W word array parametrised on DEPTH. The top level contains the handshake, fault logic and field split.

Test Plan:
- Reset, then load idx0..5 with 32'h06402083, 32'h06602103, 32'h06802183, 32'h06A02203, 32'h06C02283, 32'h06E02303; fetch 40,44,…,60 back-to-back with resp_ready=1 → six responses on consecutive cycles. First response: opcode=7'h03, rd=1, funct3=2, fault=0.
- Fetch 40 with resp_ready=0 for 3 cycles → instruction held at 32'h06402083, req_ready=0 throughout; raising resp_ready consumes the response and accepts the next request on the same edge.
- Fetch 42, 36 and 40+4*DEPTH → each returns fault=1, instruction=32'h00000013, rd=0, opcode=7'h13.
- Load idx2=32'h00208033 on the same edge as fetching 48 (old word 32'h06802183) → response is 32'h06802183; the next fetch of 48 returns 32'h00208033 with funct7_b5=0, rs2=2.
- Assert reset while resp_valid=1 → resp_valid=0 next cycle and req_ready=1; memory still returns the loaded words afterwards.

Source files
------------

// File: rtl/instr_fetch_mem_pkg.sv
// Shared constants and types for the instruction fetch memory: word width,
// the fault NOP, instruction field positions and the decoded-field bundle.
package imem_pkg;

   localparam int unsigned INSTR_W = 32;

   // addi x0, x0, 0
   localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

   // Field positions inside a 32-bit instruction word
   localparam int unsigned OPCODE_LSB    = 0;
   localparam int unsigned OPCODE_W      = 7;
   localparam int unsigned RD_LSB        = 7;
   localparam int unsigned FUNCT3_LSB    = 12;
   localparam int unsigned FUNCT3_W      = 3;
   localparam int unsigned RS1_LSB       = 15;
   localparam int unsigned RS2_LSB       = 20;
   localparam int unsigned REG_W         = 5;
   localparam int unsigned FUNCT7_B5_BIT = 30;

   typedef struct packed {
      logic                funct7_b5;
      logic [REG_W-1:0]    rs2;
      logic [REG_W-1:0]    rs1;
      logic [FUNCT3_W-1:0] funct3;
      logic [REG_W-1:0]    rd;
      logic [OPCODE_W-1:0] opcode;
   } decoded_instr_t;

endpackage

// File: rtl/instr_fetch_mem_array.sv
// Synchronous 1R1W word array. A read and a write to the same index on the
// same edge return the old word. The read register clears on reset; the
// storage itself is never cleared and stays writable during reset.
module imem_array #(
   parameter  int unsigned DEPTH = 256,
   parameter  int unsigned WIDTH = 32,
   localparam int unsigned IDX_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             rd_en,
   input  logic [IDX_W-1:0] rd_idx,
   output logic [WIDTH-1:0] rd_data,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [WIDTH-1:0] wr_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Program-load write port, independent of reset
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_idx] <= wr_data;
      end
   end

   // Registered read; holds its value when no read is issued
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= mem[rd_idx];
      end
   end

endmodule

// File: rtl/instr_fetch_mem.sv
// Instruction fetch memory: valid/ready request in, one-cycle registered
// response out with pre-split decode fields, range/alignment fault detection
// and a run-time program-load port.
module instr_fetch_mem
   import imem_pkg::*;
#(
   parameter  int unsigned          ADDR_W    = 64,
   parameter  int unsigned          DEPTH     = 256,
   parameter  logic [ADDR_W-1:0]    BASE_ADDR = ADDR_W'(40),
   parameter  logic [INSTR_W-1:0]   NOP_INSTR = imem_pkg::NOP_INSTR,
   localparam int unsigned          IDX_W     = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [ADDR_W-1:0]  req_addr,
   output logic               resp_valid,
   input  logic               resp_ready,
   output logic [INSTR_W-1:0] instruction,
   output logic [6:0]         opcode,
   output logic [4:0]         rd,
   output logic [2:0]         funct3,
   output logic [4:0]         rs1,
   output logic [4:0]         rs2,
   output logic               funct7_b5,
   output logic               fault,
   input  logic               load_en,
   input  logic [IDX_W-1:0]   load_idx,
   input  logic [INSTR_W-1:0] load_data
);

   // One extra bit so BASE_ADDR + 4*DEPTH cannot wrap
   localparam logic [ADDR_W:0] LIMIT = {1'b0, BASE_ADDR} + (ADDR_W+1)'(4 * DEPTH);

   logic                resp_valid_q;
   logic                fault_q;
   logic                accept;
   logic                addr_fault;
   logic [ADDR_W-1:0]   offset;
   logic [IDX_W-1:0]    word_idx;
   logic [INSTR_W-1:0]  mem_rdata;
   decoded_instr_t      fields;

   // Address translation and fault classification
   always_comb begin
      offset     = req_addr - BASE_ADDR;
      word_idx   = IDX_W'(offset >> 2);
      addr_fault = (req_addr[1:0] != 2'b00)
                || (req_addr < BASE_ADDR)
                || ({1'b0, req_addr} >= LIMIT);
   end

   assign req_ready = !resp_valid_q || resp_ready;
   assign accept    = req_valid && req_ready && !reset;

   // The read register inside the array doubles as the response word
   // register; faulted fetches skip the read and substitute the NOP below.
   imem_array #(
      .DEPTH (DEPTH),
      .WIDTH (INSTR_W)
   ) u_array (
      .clk     (clk),
      .reset   (reset),
      .rd_en   (accept && !addr_fault),
      .rd_idx  (word_idx),
      .rd_data (mem_rdata),
      .wr_en   (load_en),
      .wr_idx  (load_idx),
      .wr_data (load_data)
   );

   // Response valid/fault registers: load on accept, clear on idle consume
   always_ff @(posedge clk) begin
      if (reset) begin
         resp_valid_q <= 1'b0;
         fault_q      <= 1'b0;
      end else if (accept) begin
         resp_valid_q <= 1'b1;
         fault_q      <= addr_fault;
      end else if (resp_ready) begin
         resp_valid_q <= 1'b0;
      end
   end

   // Response word and field split, all derived from the same registers
   always_comb begin
      instruction      = fault_q ? NOP_INSTR : mem_rdata;
      fields           = '0;
      fields.opcode    = instruction[OPCODE_LSB +: OPCODE_W];
      fields.rd        = instruction[RD_LSB +: REG_W];
      fields.funct3    = instruction[FUNCT3_LSB +: FUNCT3_W];
      fields.rs1       = instruction[RS1_LSB +: REG_W];
      fields.rs2       = instruction[RS2_LSB +: REG_W];
      fields.funct7_b5 = instruction[FUNCT7_B5_BIT];
   end

   assign resp_valid = resp_valid_q;
   assign fault      = fault_q;
   assign opcode     = fields.opcode;
   assign rd         = fields.rd;
   assign funct3     = fields.funct3;
   assign rs1        = fields.rs1;
   assign rs2        = fields.rs2;
   assign funct7_b5  = fields.funct7_b5;

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Self-checking bench for instr_fetch_mem: directed vector table, hand-written
// multi-cycle sequences and a randomized run against a reference model.
module tb_instr_fetch_mem;

   localparam int unsigned ADDR_W = 64;
   localparam int unsigned DEPTH  = 256;
   localparam int unsigned IDX_W  = $clog2(DEPTH);
   localparam logic [63:0] BASE   = 64'd40;
   localparam logic [63:0] LIMIT  = BASE + 64'(4 * DEPTH);
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic              clk;
   logic              reset;
   logic              req_valid;
   logic              req_ready;
   logic [63:0]       req_addr;
   logic              resp_valid;
   logic              resp_ready;
   logic [31:0]       instruction;
   logic [6:0]        opcode;
   logic [4:0]        rd;
   logic [2:0]        funct3;
   logic [4:0]        rs1;
   logic [4:0]        rs2;
   logic              funct7_b5;
   logic              fault;
   logic              load_en;
   logic [IDX_W-1:0]  load_idx;
   logic [31:0]       load_data;

   instr_fetch_mem #(
      .ADDR_W    (ADDR_W),
      .DEPTH     (DEPTH),
      .BASE_ADDR (BASE),
      .NOP_INSTR (NOP)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_addr    (req_addr),
      .resp_valid  (resp_valid),
      .resp_ready  (resp_ready),
      .instruction (instruction),
      .opcode      (opcode),
      .rd          (rd),
      .funct3      (funct3),
      .rs1         (rs1),
      .rs2         (rs2),
      .funct7_b5   (funct7_b5),
      .fault       (fault),
      .load_en     (load_en),
      .load_idx    (load_idx),
      .load_data   (load_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference memory image, updated whenever the bench loads a word
   logic [31:0] mem_m [DEPTH];

   logic [31:0] prog [6] = '{32'h06402083, 32'h06602103, 32'h06802183,
                             32'h06A02203, 32'h06C02283, 32'h06E02303};

   typedef struct {
      logic [63:0] addr;
      logic [31:0] instr;
      logic        flt;
   } vec_t;

   vec_t tbl [9];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Full response check: fields are recomputed from the expected word
   task automatic chk_resp(input string tag, input logic [31:0] ei, input logic ef);
      chk({tag, ".resp_valid"},  64'(resp_valid),  64'd1);
      chk({tag, ".instruction"}, 64'(instruction), 64'(ei));
      chk({tag, ".fault"},       64'(fault),       64'(ef));
      chk({tag, ".opcode"},      64'(opcode),      64'(ei[6:0]));
      chk({tag, ".rd"},          64'(rd),          64'(ei[11:7]));
      chk({tag, ".funct3"},      64'(funct3),      64'(ei[14:12]));
      chk({tag, ".rs1"},         64'(rs1),         64'(ei[19:15]));
      chk({tag, ".rs2"},         64'(rs2),         64'(ei[24:20]));
      chk({tag, ".funct7_b5"},   64'(funct7_b5),   64'(ei[30]));
   endtask

   // What a fetch of address a should return given the current image
   task automatic ref_fetch(input logic [63:0] a, output logic [31:0] w, output logic f);
      f = (a[1:0] != 2'b00) || (a < BASE) || (a >= LIMIT);
      w = f ? NOP : mem_m[int'((a - BASE) / 64'd4)];
   endtask

   function automatic logic [63:0] rand_addr();
      logic [63:0] a;
      case ($urandom_range(0, 5))
         0, 1, 2: a = BASE + 64'(4 * $urandom_range(0, DEPTH - 1));
         3:       a = BASE + 64'(4 * $urandom_range(0, DEPTH - 1)) + 64'($urandom_range(1, 3));
         4:       a = 64'($urandom_range(0, 39));
         default: begin
            case ($urandom_range(0, 3))
               0:       a = LIMIT;
               1:       a = LIMIT + 64'd4;
               2:       a = 64'hFFFF_FFFF_FFFF_FFFC;
               default: a = {$urandom, $urandom} & ~64'd3;
            endcase
         end
      endcase
      return a;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic        mvalid;
   logic [31:0] mw;
   logic        mf;
   logic        rst_c;

   initial begin
      reset      = 1'b1;
      req_valid  = 1'b0;
      req_addr   = '0;
      resp_ready = 1'b1;
      load_en    = 1'b0;
      load_idx   = '0;
      load_data  = '0;

      // Load the whole array while reset is held
      for (int i = 0; i < DEPTH; i++) begin
         load_en   = 1'b1;
         load_idx  = IDX_W'(i);
         load_data = (i < 6) ? prog[i] : $urandom;
         mem_m[i]  = load_data;
         step();
      end
      load_en = 1'b0;
      step();
      reset = 1'b0;

      chk("rst.resp_valid",  64'(resp_valid),  64'd0);
      chk("rst.instruction", 64'(instruction), 64'd0);
      chk("rst.fault",       64'(fault),       64'd0);
      chk("rst.opcode",      64'(opcode),      64'd0);
      chk("rst.rd",          64'(rd),          64'd0);
      chk("rst.req_ready",   64'(req_ready),   64'd1);

      // Directed vectors: six back-to-back fetches then three faults
      for (int i = 0; i < 6; i++) begin
         tbl[i].addr  = BASE + 64'(4 * i);
         tbl[i].instr = prog[i];
         tbl[i].flt   = 1'b0;
      end
      tbl[6] = '{addr: 64'd42, instr: NOP, flt: 1'b1};
      tbl[7] = '{addr: 64'd36, instr: NOP, flt: 1'b1};
      tbl[8] = '{addr: LIMIT,  instr: NOP, flt: 1'b1};

      resp_ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         req_valid = 1'b1;
         req_addr  = tbl[i].addr;
         step();
         chk_resp($sformatf("vec%0d", i), tbl[i].instr, tbl[i].flt);
         if (i == 0) begin
            chk("vec0.opcode_lit", 64'(opcode), 64'h03);
            chk("vec0.rd_lit",     64'(rd),     64'd1);
            chk("vec0.funct3_lit", 64'(funct3), 64'd2);
         end
         if (i >= 6) begin
            chk("fault.rd_lit",     64'(rd),     64'd0);
            chk("fault.opcode_lit", 64'(opcode), 64'h13);
         end
      end
      req_valid = 1'b0;
      step();
      chk("idle.resp_valid", 64'(resp_valid), 64'd0);

      // Backpressure: response held, no accept, then consume+accept together
      resp_ready = 1'b0;
      req_valid  = 1'b1;
      req_addr   = 64'd40;
      step();
      chk_resp("bp.first", prog[0], 1'b0);
      req_addr = 64'd44;
      for (int i = 0; i < 3; i++) begin
         step();
         chk_resp("bp.hold", prog[0], 1'b0);
         chk("bp.req_ready", 64'(req_ready), 64'd0);
      end
      resp_ready = 1'b1;
      #1;
      chk("bp.req_ready_rise", 64'(req_ready), 64'd1);
      step();
      chk_resp("bp.b2b", prog[1], 1'b0);
      req_valid = 1'b0;
      step();
      chk("bp.idle", 64'(resp_valid), 64'd0);

      // Load and fetch of the same index on one edge returns the old word
      req_valid = 1'b1;
      req_addr  = 64'd48;
      load_en   = 1'b1;
      load_idx  = IDX_W'(2);
      load_data = 32'h00208033;
      step();
      load_en  = 1'b0;
      mem_m[2] = 32'h00208033;
      chk_resp("coll.old", 32'h06802183, 1'b0);
      step();
      chk_resp("coll.new", 32'h00208033, 1'b0);
      chk("coll.funct7_b5_lit", 64'(funct7_b5), 64'd0);
      chk("coll.rs2_lit",       64'(rs2),       64'd2);
      req_valid = 1'b0;
      step();

      // Reset with a pending response; request in the reset cycle is dropped
      resp_ready = 1'b0;
      req_valid  = 1'b1;
      req_addr   = 64'd40;
      step();
      chk("mrst.pending", 64'(resp_valid), 64'd1);
      reset    = 1'b1;
      req_addr = 64'd44;
      step();
      reset     = 1'b0;
      req_valid = 1'b0;
      #1;
      chk("mrst.resp_valid", 64'(resp_valid), 64'd0);
      chk("mrst.req_ready",  64'(req_ready),  64'd1);
      step();
      chk("mrst.no_accept", 64'(resp_valid), 64'd0);
      resp_ready = 1'b1;
      req_valid  = 1'b1;
      req_addr   = 64'd40;
      step();
      chk_resp("mrst.refetch", prog[0], 1'b0);
      req_valid = 1'b0;
      step();

      // Randomized traffic against the reference model
      mvalid = 1'b0;
      mw     = '0;
      mf     = 1'b0;
      for (int c = 0; c < 600; c++) begin
         rst_c      = ($urandom_range(0, 49) == 0);
         reset      = rst_c;
         req_valid  = ($urandom_range(0, 3) != 0);
         resp_ready = ($urandom_range(0, 2) != 0);
         req_addr   = rand_addr();
         load_en    = ($urandom_range(0, 4) == 0);
         load_idx   = IDX_W'($urandom_range(0, DEPTH - 1));
         load_data  = $urandom;
         #1;
         chk("rnd.req_ready", 64'(req_ready), 64'(!mvalid || resp_ready));

         if (rst_c) begin
            mvalid = 1'b0;
         end else if (req_valid && (!mvalid || resp_ready)) begin
            ref_fetch(req_addr, mw, mf);
            mvalid = 1'b1;
         end else if (resp_ready) begin
            mvalid = 1'b0;
         end
         if (load_en) mem_m[load_idx] = load_data;

         step();
         chk("rnd.resp_valid", 64'(resp_valid), 64'(mvalid));
         if (mvalid) chk_resp("rnd", mw, mf);
      end

      reset     = 1'b0;
      req_valid = 1'b0;
      load_en   = 1'b0;
      step();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   // Absolute time limit so the run always ends
   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish, got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
